lza_norm_shifter: RTL and testbench
===================================

Name: lza_norm_shifter

Overview:
- Consumer end of the leading-zero-anticipation path. Takes an unnormalized significand, the registered LZA shift value and the pre-normalization biased exponent.
- Performs a left-shift normalization, then the single-bit LZA error correction, then the exponent adjustment.
- Sits between the add/sub significand adder and the rounding stage.
- Multi-cycle, with a start/ready/valid handshake.

Parameters:
- SWR, 26, significand word width (26 single, 55 double).
- EWR, 5, shift-value width (5 single, 6 double).
- EW, 8, biased exponent width (8 single, 11 double).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- start_i  in  1  request; sampled only when ready_o=1.
- Data_i  in  SWR  unnormalized significand.
- Shift_Value_i  in  EWR  LZA anticipated leading-zero count. It is exact or one short.
- Exp_i  in  EW  biased exponent before normalization.
- ready_o  out  1  high in IDLE.
- valid_o  out  1  one-cycle pulse; result valid.
- Data_o  out  SWR  normalized significand; MSB=1 unless zero_o or underflow_o.
- Exp_o  out  EW  adjusted biased exponent.
- zero_o  out  1  input significand was zero.
- underflow_o  out  1  exponent underflowed; result flushed to zero.

Behaviour:
- Reset (rst=0 at an edge): state goes to IDLE. All outputs are 0 except ready_o=1. This applies mid-operation too: the in-flight job is discarded and valid_o is not raised.
- FSM states and transitions:
  - IDLE: ready_o=1. On start_i=1, capture Data_i, Shift_Value_i and Exp_i into internal registers, then go to SHIFT.
  - SHIFT:
    - Shift amount sh = min(Shift_Value_i, SWR-1).
    - Register d = captured data << sh (zero-filled) and e_tot = sh.
    - If the captured data = 0, set zero flag.
    - Go to CORRECT.
  - CORRECT:
    - If zero flag is set, skip.
    - Else, if d[SWR-1]=0, then d <= d<<1 and e_tot <= e_tot+1. Only one correction step is performed.
    - Underflow check: underflow if captured Exp_i <= e_tot, compared unsigned in EW+1 bits.
    - Go to DONE.
  - DONE: update the outputs and pulse valid_o=1 for this cycle, then go to IDLE.
- Output values set in DONE:
  - Normal case: Data_o=d, Exp_o=Exp_i-e_tot, zero_o=0, underflow_o=0.
  - Zero case: Data_o=0, Exp_o=0, zero_o=1, underflow_o=0.
  - Underflow case: Data_o=0, Exp_o=0, zero_o=0, underflow_o=1.
- Latency: start_i accepted at edge t gives valid_o=1 during the cycle after edge t+3. Throughput is one job per 4 cycles.
- Outputs hold their last values until the next DONE. zero_o and underflow_o are result-qualified, not pulses.
- start_i while ready_o=0 is ignored (no queueing). Input ports are don't-care outside the capture edge.
- An overestimated Shift_Value_i (greater than the true leading-zero count) is outside the contract and is not detected. Bits shifted out are lost.
- A Shift_Value_i of SWR or more with nonzero data is clamped to SWR-1. The correction step then still applies.
- Implementation constraint: no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. SWR=26, EW=8; Data_i=0x0080000, Shift_Value_i=6, Exp_i=100, start_i pulse at t -> ready_o=0 for 3 cycles, then valid_o=1 at t+4 with Data_o=0x2000000, Exp_o=94, zero_o=0, underflow_o=0.
2. LZA one short: Data_i=0x0080000, Shift_Value_i=5, Exp_i=100 -> correction fires; Data_o=0x2000000, Exp_o=94.
3. Zero input: Data_i=0, Shift_Value_i=31, Exp_i=50 -> Data_o=0, Exp_o=0, zero_o=1, underflow_o=0.
4. Underflow: Data_i=0x0000001, Shift_Value_i=25, Exp_i=10 -> underflow_o=1, Data_o=0, Exp_o=0. Boundary case: Exp_i=26 -> underflow_o=0, Exp_o=1, Data_o=0x2000000.
5. Busy rejection: second start_i with Data_i=0x1000000 issued during SHIFT -> first result only; ready_o returns 1 after DONE; a second result never appears.
6. Reset mid-operation: rst=0 during CORRECT -> next edge ready_o=1, valid_o=0, all outputs 0. A new job after reset completes normally (rerun scenario 1).

Source files
------------

// File: rtl/lza_norm_shifter.sv
// LZA consumer: left-shift normalization, one-bit LZA correction and exponent
// adjustment, sequenced IDLE -> SHIFT -> CORRECT -> DONE with all outputs registered.
module lza_norm_shifter #(
  parameter int SWR = 26,
  parameter int EWR = 5,
  parameter int EW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [SWR-1:0] Data_i,
  input  logic [EWR-1:0] Shift_Value_i,
  input  logic [EW-1:0]  Exp_i,
  output logic           ready_o,
  output logic           valid_o,
  output logic [SWR-1:0] Data_o,
  output logic [EW-1:0]  Exp_o,
  output logic           zero_o,
  output logic           underflow_o
);

  localparam int ETW = $clog2(SWR + 1);
  localparam int CW  = (EW + 1 > ETW) ? EW + 1 : ETW;

  typedef enum logic [1:0] {IDLE, SHIFT, CORRECT, DONE} state_t;

  state_t         state_q;
  logic [SWR-1:0] data_q;
  logic [EWR-1:0] sv_q;
  logic [EW-1:0]  exp_q;
  logic [SWR-1:0] d_q;
  logic [ETW-1:0] etot_q;
  logic           zero_q;
  logic           uf_q;
  logic           valid_q;
  logic [SWR-1:0] data_out_q;
  logic [EW-1:0]  exp_out_q;
  logic           zero_out_q;
  logic           uf_out_q;

  logic [ETW-1:0] sh;
  logic [SWR-1:0] shifted_d;
  logic [SWR-1:0] d_corr_d;
  logic [ETW-1:0] etot_corr_d;
  logic           uf_d;
  logic [EW-1:0]  exp_adj;

  always_comb begin
    sh = ETW'(sv_q);
    if (32'(sv_q) > 32'(SWR - 1)) sh = ETW'(SWR - 1);
    shifted_d = data_q << sh;

    // Single correction step: the LZA estimate is exact or one short.
    d_corr_d    = d_q;
    etot_corr_d = etot_q;
    if (!zero_q && !d_q[SWR-1]) begin
      d_corr_d    = d_q << 1;
      etot_corr_d = etot_q + ETW'(1);
    end

    uf_d    = !zero_q && (CW'(exp_q) <= CW'(etot_corr_d));
    exp_adj = exp_q - EW'(etot_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      sv_q       <= '0;
      exp_q      <= '0;
      d_q        <= '0;
      etot_q     <= '0;
      zero_q     <= 1'b0;
      uf_q       <= 1'b0;
      valid_q    <= 1'b0;
      data_out_q <= '0;
      exp_out_q  <= '0;
      zero_out_q <= 1'b0;
      uf_out_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            data_q  <= Data_i;
            sv_q    <= Shift_Value_i;
            exp_q   <= Exp_i;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          d_q     <= shifted_d;
          etot_q  <= sh;
          zero_q  <= (data_q == '0);
          uf_q    <= 1'b0;
          state_q <= CORRECT;
        end
        CORRECT: begin
          d_q     <= d_corr_d;
          etot_q  <= etot_corr_d;
          uf_q    <= uf_d;
          state_q <= DONE;
        end
        DONE: begin
          valid_q <= 1'b1;
          if (zero_q) begin
            data_out_q <= '0;
            exp_out_q  <= '0;
            zero_out_q <= 1'b1;
            uf_out_q   <= 1'b0;
          end else if (uf_q) begin
            data_out_q <= '0;
            exp_out_q  <= '0;
            zero_out_q <= 1'b0;
            uf_out_q   <= 1'b1;
          end else begin
            data_out_q <= d_q;
            exp_out_q  <= exp_adj;
            zero_out_q <= 1'b0;
            uf_out_q   <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign valid_o     = valid_q;
  assign Data_o      = data_out_q;
  assign Exp_o       = exp_out_q;
  assign zero_o      = zero_out_q;
  assign underflow_o = uf_out_q;

endmodule

// File: tb/tb_lza_norm_shifter.sv
// Directed bench for lza_norm_shifter: expected results are queued at issue
// and compared against each valid_o pulse.
module tb_lza_norm_shifter;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [25:0] Data_i;
  logic [4:0]  Shift_Value_i;
  logic [7:0]  Exp_i;
  logic        ready_o;
  logic        valid_o;
  logic [25:0] Data_o;
  logic [7:0]  Exp_o;
  logic        zero_o;
  logic        underflow_o;

  typedef struct packed {
    logic [25:0] data;
    logic [7:0]  exp;
    logic        zero;
    logic        uf;
  } res_t;

  res_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;

  lza_norm_shifter #(.SWR(26), .EWR(5), .EW(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .Data_i(Data_i),
    .Shift_Value_i(Shift_Value_i), .Exp_i(Exp_i), .ready_o(ready_o),
    .valid_o(valid_o), .Data_o(Data_o), .Exp_o(Exp_o), .zero_o(zero_o),
    .underflow_o(underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: true leading-zero count gives the normalized result directly.
  function automatic res_t model(input logic [25:0] d, input logic [7:0] e);
    res_t r;
    int   lz;
    bit   found;
    r = '0;
    lz = 26;
    found = 0;
    for (int i = 25; i >= 0; i--) begin
      if (!found && d[i]) begin
        lz = 25 - i;
        found = 1;
      end
    end
    if (d == 26'd0) r.zero = 1'b1;
    else if (int'(e) <= lz) r.uf = 1'b1;
    else begin
      r.data = d << lz;
      r.exp  = 8'(int'(e) - lz);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (valid_o) begin
      res_t r;
      n_valid++;
      check("unexpected_valid", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        r = sb.pop_front();
        check("Data_o", 64'(Data_o), 64'(r.data));
        check("Exp_o", 64'(Exp_o), 64'(r.exp));
        check("zero_o", 64'(zero_o), 64'(r.zero));
        check("underflow_o", 64'(underflow_o), 64'(r.uf));
      end
    end
  end

  task automatic issue(input logic [25:0] d, input logic [4:0] s, input logic [7:0] e);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(ready_o), 64'd1);
    start_i = 1'b1;
    Data_i = d;
    Shift_Value_i = s;
    Exp_i = e;
    sb.push_back(model(d, e));
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", 64'(sb.size() == 0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_valid"}, 64'(valid_o), 64'd0);
    check({tag, "_data"}, 64'(Data_o), 64'd0);
    check({tag, "_exp"}, 64'(Exp_o), 64'd0);
    check({tag, "_zero"}, 64'(zero_o), 64'd0);
    check({tag, "_uf"}, 64'(underflow_o), 64'd0);
  endtask

  initial begin
    int v0;
    rst = 1'b0;
    start_i = 1'b0;
    Data_i = '0;
    Shift_Value_i = '0;
    Exp_i = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b1;

    // Scenario 1 with handshake timing
    issue(26'h0080000, 5'd6, 8'd100);
    repeat (3) begin
      @(negedge clk);
      check("busy_ready", 64'(ready_o), 64'd0);
    end
    @(negedge clk);
    check("latency_valid", 64'(valid_o), 64'd1);
    check("latency_ready", 64'(ready_o), 64'd1);
    check("s1_data_const", 64'(Data_o), 64'h2000000);
    check("s1_exp_const", 64'(Exp_o), 64'd94);
    @(negedge clk);
    check("valid_pulse", 64'(valid_o), 64'd0);
    wait_done();

    issue(26'h0080000, 5'd5, 8'd100); wait_done();
    issue(26'h0000000, 5'd31, 8'd50); wait_done();
    repeat (3) @(negedge clk);
    check("zero_hold", 64'(zero_o), 64'd1);
    issue(26'h0000001, 5'd25, 8'd10); wait_done();
    check("uf_const", 64'(underflow_o), 64'd1);
    issue(26'h0000001, 5'd25, 8'd26); wait_done();
    check("uf_bound_exp", 64'(Exp_o), 64'd1);
    issue(26'h0000001, 5'd24, 8'd25); wait_done();
    issue(26'h0000001, 5'd31, 8'd100); wait_done();
    issue(26'h2345678, 5'd0, 8'd3); wait_done();
    issue(26'h0000003, 5'd23, 8'd40); wait_done();

    // Busy rejection: second start during SHIFT is dropped
    v0 = n_valid;
    issue(26'h0080000, 5'd6, 8'd100);
    @(negedge clk);
    start_i = 1'b1;
    Data_i = 26'h1000000;
    Shift_Value_i = 5'd1;
    Exp_i = 8'd77;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    check("busy_single_result", 64'(n_valid), 64'(v0 + 1));
    check("busy_ready_back", 64'(ready_o), 64'd1);

    // Reset while in CORRECT discards the job
    v0 = n_valid;
    issue(26'h0000003, 5'd23, 8'd40);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 check_reset_outputs("midreset");
    @(negedge clk) rst = 1'b1;
    repeat (8) @(negedge clk);
    check("midreset_no_valid", 64'(n_valid), 64'(v0));

    issue(26'h0080000, 5'd6, 8'd100); wait_done();
    check("post_reset_result", 64'(n_valid), 64'(v0 + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
